// File: rtl/nanorv32_gpio_if.sv
// Bus request/response bundle between the peripheral mux and the GPIO block.
// The master modport belongs to the peripheral mux and the slave modport to the GPIO block.
interface nanorv32_gpio_if #(
  parameter int ADDR_MSB = 15,
  parameter int DATA_MSB = 31
) ();
  logic [ADDR_MSB:0] bus_gpio_addr;
  logic [3:0]        bus_gpio_bytesel;
  logic [DATA_MSB:0] bus_gpio_din;
  logic              bus_gpio_en;
  logic [DATA_MSB:0] gpio_bus_dout;
  logic              gpio_bus_ready_nxt;

  modport master (
    output bus_gpio_addr,
    output bus_gpio_bytesel,
    output bus_gpio_din,
    output bus_gpio_en,
    input  gpio_bus_dout,
    input  gpio_bus_ready_nxt
  );

  modport slave (
    input  bus_gpio_addr,
    input  bus_gpio_bytesel,
    input  bus_gpio_din,
    input  bus_gpio_en,
    output gpio_bus_dout,
    output gpio_bus_ready_nxt
  );
endinterface

// File: rtl/nanorv32_gpio.sv
// Memory-mapped GPIO with per-pin direction, a 2-flop input synchroniser,
// edge-detect interrupt status bits (write-1-to-clear) and one combined interrupt line.
module nanorv32_gpio #(
  parameter int NANORV32_PERIPH_ADDR_MSB = 15,
  parameter int NANORV32_DATA_MSB        = 31,
  parameter int NB_GPIO                  = 32
) (
  input  logic               clk_in,
  input  logic               rst_n,
  nanorv32_gpio_if.slave     bus,
  input  logic [NB_GPIO-1:0] gpio_in,
  output logic [NB_GPIO-1:0] gpio_out,
  output logic [NB_GPIO-1:0] gpio_oe,
  output logic               gpio_irq
);
  localparam int DW = NANORV32_DATA_MSB + 1;

  localparam logic [5:0] REG_DOUT     = 6'd0;
  localparam logic [5:0] REG_DIR      = 6'd1;
  localparam logic [5:0] REG_DIN      = 6'd2;
  localparam logic [5:0] REG_IRQ_EN   = 6'd3;
  localparam logic [5:0] REG_IRQ_POL  = 6'd4;
  localparam logic [5:0] REG_IRQ_STAT = 6'd5;

  function automatic logic [DW-1:0] widen(input logic [NB_GPIO-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    r[NB_GPIO-1:0] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [3:0]    be);
    logic [DW-1:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        r[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        r[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return r;
  endfunction

  logic [NB_GPIO-1:0] dout_q, dout_d;
  logic [NB_GPIO-1:0] dir_q, dir_d;
  logic [NB_GPIO-1:0] irq_en_q, irq_en_d;
  logic [NB_GPIO-1:0] irq_pol_q, irq_pol_d;
  logic [NB_GPIO-1:0] irq_stat_q, irq_stat_d;
  logic [NB_GPIO-1:0] sync1_q, sync1_d;
  logic [NB_GPIO-1:0] sync2_q, sync2_d;
  logic [NB_GPIO-1:0] prev_q, prev_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic               ready_q, ready_d;

  logic               wr_s;
  logic               rd_s;
  logic [5:0]         word_s;
  logic [DW-1:0]      lane_mask_s;
  logic [DW-1:0]      rd_mux_s;
  logic [DW-1:0]      wdata_s;
  logic [DW-1:0]      w1c_full_s;
  logic [NB_GPIO-1:0] w1c_s;
  logic [NB_GPIO-1:0] event_s;
  logic               unused_s;

  // Only word-offset bits [7:2] select a register; higher address bits alias.
  assign unused_s = ^{bus.bus_gpio_addr[NANORV32_PERIPH_ADDR_MSB:8], bus.bus_gpio_addr[1:0]};

  // Bus decode, register next-state, edge detection and read mux.
  always_comb begin
    wr_s        = bus.bus_gpio_en & (|bus.bus_gpio_bytesel);
    rd_s        = bus.bus_gpio_en & ~(|bus.bus_gpio_bytesel);
    word_s      = bus.bus_gpio_addr[7:2];
    lane_mask_s = {{8{bus.bus_gpio_bytesel[3]}}, {8{bus.bus_gpio_bytesel[2]}},
                   {8{bus.bus_gpio_bytesel[1]}}, {8{bus.bus_gpio_bytesel[0]}}};

    case (word_s)
      REG_DOUT:     rd_mux_s = widen(dout_q);
      REG_DIR:      rd_mux_s = widen(dir_q);
      REG_DIN:      rd_mux_s = widen(sync2_q);
      REG_IRQ_EN:   rd_mux_s = widen(irq_en_q);
      REG_IRQ_POL:  rd_mux_s = widen(irq_pol_q);
      REG_IRQ_STAT: rd_mux_s = widen(irq_stat_q);
      default:      rd_mux_s = '0;
    endcase

    // Merging against the selected register keeps unstrobed lanes intact.
    wdata_s    = lane_merge(rd_mux_s, bus.bus_gpio_din, bus.bus_gpio_bytesel);
    w1c_full_s = bus.bus_gpio_din & lane_mask_s;

    dout_d    = dout_q;
    dir_d     = dir_q;
    irq_en_d  = irq_en_q;
    irq_pol_d = irq_pol_q;
    w1c_s     = '0;
    if (wr_s) begin
      case (word_s)
        REG_DOUT:     dout_d    = wdata_s[NB_GPIO-1:0];
        REG_DIR:      dir_d     = wdata_s[NB_GPIO-1:0];
        REG_IRQ_EN:   irq_en_d  = wdata_s[NB_GPIO-1:0];
        REG_IRQ_POL:  irq_pol_d = wdata_s[NB_GPIO-1:0];
        REG_IRQ_STAT: w1c_s     = w1c_full_s[NB_GPIO-1:0];
        default:      w1c_s     = '0;
      endcase
    end else begin
      w1c_s = '0;
    end

    sync1_d = gpio_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;

    // Polarity bit picks falling (1) or rising (0); a new event beats a same-cycle clear.
    event_s    = (sync2_q & ~prev_q & ~irq_pol_q) | (~sync2_q & prev_q & irq_pol_q);
    irq_stat_d = (irq_stat_q & ~w1c_s) | event_s;
    irq_d      = |(irq_stat_q & irq_en_q);

    if (rd_s) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = rdata_q;
    end
    ready_d = 1'b1;
  end

  // All state flops, cleared asynchronously by rst_n.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_pol_q  <= '0;
      irq_stat_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      irq_pol_q  <= irq_pol_d;
      irq_stat_q <= irq_stat_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      ready_q    <= ready_d;
    end
  end

  assign gpio_out               = dout_q;
  assign gpio_oe                = dir_q;
  assign gpio_irq               = irq_q;
  assign bus.gpio_bus_dout      = rdata_q;
  assign bus.gpio_bus_ready_nxt = ready_q;
endmodule

// File: tb/tb_nanorv32_gpio.sv
// Self-checking bench for nanorv32_gpio: directed register/interrupt scenarios with
// literal expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_nanorv32_gpio;
  localparam int AMSB = 15;
  localparam int NB   = 32;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic [NB-1:0] gpio_in;
  logic [NB-1:0] gpio_out;
  logic [NB-1:0] gpio_oe;
  logic          gpio_irq;

  int n_checks = 0;
  int n_fail   = 0;

  nanorv32_gpio_if #(.ADDR_MSB(AMSB), .DATA_MSB(31)) bus_if ();

  nanorv32_gpio #(
    .NANORV32_PERIPH_ADDR_MSB(AMSB),
    .NANORV32_DATA_MSB(31),
    .NB_GPIO(NB)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .bus     (bus_if.slave),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .gpio_irq(gpio_irq)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: register file as an array, input path as a history of samples.
  logic [31:0] m_reg [6];
  logic [31:0] m_rdata;
  logic        m_irq;
  logic        m_ready;
  logic [31:0] hist [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = 32'h0;
    for (int i = 0; i < 3; i++) hist[i] = 32'h0;
    m_rdata = 32'h0;
    m_irq   = 1'b0;
    m_ready = 1'b0;
  endtask

  // One clock edge of the spec: hist[k] holds the pad value sampled k+1 edges ago.
  task automatic model_edge();
    logic [31:0] cur [6];
    logic [31:0] ev;
    logic [31:0] clr;
    int          ofs;
    logic        irq_next;
    for (int i = 0; i < 6; i++) cur[i] = m_reg[i];
    cur[2] = hist[1];
    ev = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (m_reg[4][i]) ev[i] = ~hist[1][i] & hist[2][i];
      else             ev[i] = hist[1][i] & ~hist[2][i];
    end
    irq_next = ((m_reg[5] & m_reg[3]) != 32'h0);
    ofs = (int'(bus_if.bus_gpio_addr) % 256) / 4;
    if (bus_if.bus_gpio_en && bus_if.bus_gpio_bytesel == 4'h0) begin
      m_rdata = (ofs < 6) ? cur[ofs] : 32'h0;
    end
    if (bus_if.bus_gpio_en && bus_if.bus_gpio_bytesel != 4'h0) begin
      clr = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (bus_if.bus_gpio_bytesel[k]) begin
          if (ofs == 0 || ofs == 1 || ofs == 3 || ofs == 4)
            m_reg[ofs][8*k +: 8] = bus_if.bus_gpio_din[8*k +: 8];
          clr[8*k +: 8] = bus_if.bus_gpio_din[8*k +: 8];
        end
      end
      if (ofs == 5) m_reg[5] = m_reg[5] & ~clr;
    end
    m_reg[5] = m_reg[5] | ev;
    m_irq    = irq_next;
    m_ready  = 1'b1;
    hist[2]  = hist[1];
    hist[1]  = hist[0];
    hist[0]  = gpio_in;
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  // Compare all outputs against the model away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk_in);
      check("gpio_out", gpio_out, m_reg[0]);
      check("gpio_oe", gpio_oe, m_reg[1]);
      check("gpio_irq", {31'h0, gpio_irq}, {31'h0, m_irq});
      check("dout", bus_if.gpio_bus_dout, m_rdata);
      check("ready_nxt", {31'h0, bus_if.gpio_bus_ready_nxt}, {31'h0, m_ready});
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step(input logic en, input logic [AMSB:0] a, input logic [3:0] be,
                      input logic [31:0] d);
    bus_if.bus_gpio_en      = en;
    bus_if.bus_gpio_addr    = a;
    bus_if.bus_gpio_bytesel = be;
    bus_if.bus_gpio_din     = d;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0000, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [AMSB:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b1, a, be, d);
  endtask

  task automatic rd(input logic [AMSB:0] a);
    step(1'b1, a, 4'h0, 32'h0);
  endtask

  initial begin : stim
    logic [31:0] r;
    logic [31:0] r2;
    bus_if.bus_gpio_en      = 1'b0;
    bus_if.bus_gpio_addr    = 16'h0000;
    bus_if.bus_gpio_bytesel = 4'h0;
    bus_if.bus_gpio_din     = 32'h0;
    gpio_in = 32'h0;

    repeat (3) @(posedge clk_in);
    #1;
    check("reset_ready", {31'h0, bus_if.gpio_bus_ready_nxt}, 32'h0);
    check("reset_out", gpio_out, 32'h0);
    rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", {31'h0, bus_if.gpio_bus_ready_nxt}, 32'h1);

    // Byte-lane writes
    wr(16'h0000, 4'hF, 32'hA5A5_A5A5);
    wr(16'h0000, 4'h2, 32'h1234_5678);
    check("byte_write_out", gpio_out, 32'hA5A5_56A5);
    rd(16'h0000);
    check("byte_write_read", bus_if.gpio_bus_dout, 32'hA5A5_56A5);
    wr(16'h0004, 4'hF, 32'h0000_FFFF);
    check("dir_oe", gpio_oe, 32'h0000_FFFF);
    wr(16'h0004, 4'h0 | 4'h1, 32'h0000_0000);
    check("dout_holds_on_write", bus_if.gpio_bus_dout, 32'hA5A5_56A5);

    // Input synchroniser latency, reserved offset, aliasing
    gpio_in = 32'h0000_0001;
    idle(1);
    rd(16'h0008);
    check("din_1cycle", bus_if.gpio_bus_dout, 32'h0);
    rd(16'h0008);
    check("din_2cycle", bus_if.gpio_bus_dout, 32'h1);
    rd(16'h0040);
    check("reserved_read", bus_if.gpio_bus_dout, 32'h0);
    rd(16'h0100);
    check("alias_read", bus_if.gpio_bus_dout, 32'hA5A5_56A5);
    gpio_in = 32'h0;
    idle(4);
    wr(16'h0014, 4'hF, 32'hFFFF_FFFF);
    rd(16'h0014);
    check("stat_cleared", bus_if.gpio_bus_dout, 32'h0);

    // Rising interrupt then W1C
    wr(16'h000C, 4'hF, 32'h1);
    wr(16'h0010, 4'hF, 32'h0);
    idle(2);
    gpio_in = 32'h1;
    idle(2);
    check("rise_irq_e2", {31'h0, gpio_irq}, 32'h0);
    idle(1);
    check("rise_irq_e3", {31'h0, gpio_irq}, 32'h0);
    idle(1);
    check("rise_irq_e4", {31'h0, gpio_irq}, 32'h1);
    rd(16'h0014);
    check("rise_stat", bus_if.gpio_bus_dout, 32'h1);
    wr(16'h0014, 4'h1, 32'h1);
    check("w1c_irq_same", {31'h0, gpio_irq}, 32'h1);
    idle(1);
    check("w1c_irq_next", {31'h0, gpio_irq}, 32'h0);
    rd(16'h0014);
    check("w1c_stat", bus_if.gpio_bus_dout, 32'h0);

    // Falling event while masked, then enable
    wr(16'h000C, 4'hF, 32'h0);
    wr(16'h0010, 4'hF, 32'h2);
    gpio_in = 32'h3;
    idle(4);
    wr(16'h0014, 4'hF, 32'hFFFF_FFFF);
    gpio_in = 32'h1;
    idle(3);
    rd(16'h0014);
    check("fall_stat", bus_if.gpio_bus_dout, 32'h2);
    idle(2);
    check("fall_masked_irq", {31'h0, gpio_irq}, 32'h0);
    wr(16'h000C, 4'hF, 32'h2);
    check("enable_irq_same", {31'h0, gpio_irq}, 32'h0);
    idle(1);
    check("enable_irq_next", {31'h0, gpio_irq}, 32'h1);

    // Set wins over a same-cycle clear
    wr(16'h000C, 4'hF, 32'h0);
    gpio_in = 32'h0;
    idle(4);
    wr(16'h0014, 4'hF, 32'hFFFF_FFFF);
    gpio_in = 32'h1;
    idle(2);
    wr(16'h0014, 4'h1, 32'h1);
    rd(16'h0014);
    check("set_wins", bus_if.gpio_bus_dout, 32'h1);

    // Randomized back-to-back traffic
    for (int i = 0; i < 2000; i++) begin
      r  = $urandom;
      r2 = $urandom;
      if (r[3:0] == 4'h0) begin
        r2[7:0] = r2[7:0];
      end else begin
        r2[7:2] = {3'b000, r[6:4] % 3'd6 == 3'd0 ? r[6:4] : r[6:4] % 3'd6};
      end
      if (r[9:8] == 2'b00) gpio_in = gpio_in ^ (32'd1 << r[14:10]);
      if (r[20:19] == 2'b00) gpio_in = gpio_in ^ $urandom;
      step(r[18:17] != 2'b00, r2[AMSB:0], (r[16:15] == 2'b00) ? 4'h0 : r[24:21], $urandom);
    end

    // Asynchronous reset in the middle of a write cycle
    wr(16'h0000, 4'hF, 32'hFFFF_FFFF);
    wr(16'h0004, 4'hF, 32'hFFFF_FFFF);
    rd(16'h0000);
    check("pre_reset_out", gpio_out, 32'hFFFF_FFFF);
    bus_if.bus_gpio_en      = 1'b1;
    bus_if.bus_gpio_bytesel = 4'hF;
    bus_if.bus_gpio_addr    = 16'h000C;
    bus_if.bus_gpio_din     = 32'hFFFF_FFFF;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", gpio_out, 32'h0);
    check("async_rst_oe", gpio_oe, 32'h0);
    check("async_rst_irq", {31'h0, gpio_irq}, 32'h0);
    check("async_rst_dout", bus_if.gpio_bus_dout, 32'h0);
    check("async_rst_ready", {31'h0, bus_if.gpio_bus_ready_nxt}, 32'h0);
    @(posedge clk_in);
    #1;
    check("rst_hold_ready", {31'h0, bus_if.gpio_bus_ready_nxt}, 32'h0);
    bus_if.bus_gpio_en = 1'b0;
    rst_n = 1'b1;
    idle(2);
    rd(16'h000C);
    check("rst_discard_write", bus_if.gpio_bus_dout, 32'h0);
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nanorv32_gpio.md
Name: nanorv32_gpio

Overview:
Memory-mapped GPIO peripheral directly downstream of the peripheral mux. It consumes the bus_gpio_* request and returns gpio_bus_dout and gpio_bus_ready_nxt. It provides per-pin direction, output data, a 2-flop synchronised input, edge-detect interrupt flags and one combined interrupt line to the core.

Parameters:
NANORV32_PERIPH_ADDR_MSB, from nanorv32_parameters.v, MSB of the peripheral address bus.
NANORV32_DATA_MSB, 31 (from nanorv32_parameters.v), MSB of the data bus.
NB_GPIO, 32, number of pins (1..32); register bits at and above NB_GPIO read 0 and ignore writes.

Ports:
clk_in  input  1  system clock, all flops on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
bus_gpio_addr  input  NANORV32_PERIPH_ADDR_MSB+1  byte address; only bits [7:2] decoded
bus_gpio_bytesel  input  4  byte strobes; non-zero marks a write, zero marks a read
bus_gpio_din  input  32  write data
bus_gpio_en  input  1  access request, one cycle per access
gpio_bus_dout  output  32  read data, registered
gpio_bus_ready_nxt  output  1  slave will complete the access presented this cycle
gpio_in  input  NB_GPIO  asynchronous pad inputs
gpio_out  output  NB_GPIO  pad output values
gpio_oe  output  NB_GPIO  pad output enables (1 = drive)
gpio_irq  output  1  level interrupt to core

Behaviour:
- Reset is asynchronous, active-low (rst_n). Clock is clk_in; there is no other clock.
- Reset values: all registers 0; gpio_out, gpio_oe, gpio_irq, gpio_bus_dout all 0; gpio_bus_ready_nxt 0 while rst_n is low; synchroniser and previous-value flops 0.
- Register map (offset = addr[7:2]*4):
  - 0x00 DOUT, RW
  - 0x04 DIR, RW, 1 = output
  - 0x08 DIN, RO, synchronised input
  - 0x0C IRQ_EN, RW
  - 0x10 IRQ_POL, RW, 0 = rising, 1 = falling
  - 0x14 IRQ_STAT, R / W1C
  - 0x18-0xFC: reserved, read 0, writes ignored. Address bits above 7 are ignored (aliasing).
- Write: bus_gpio_en=1 and bytesel!=0. Each byte lane k is updated only if bytesel[k]=1. The register updates at the clock edge ending the request cycle.
- Read: bus_gpio_en=1 and bytesel==0. gpio_bus_dout is loaded at that edge and is valid the following cycle (1-cycle read latency). It holds its value until the next read; writes do not change it.
- gpio_bus_ready_nxt is 1 every cycle out of reset (zero wait states). Back-to-back accesses on consecutive cycles are legal.
- A read of any register in the same cycle as a write to it returns the pre-write value.
- gpio_out = DOUT. gpio_oe = DIR. Both come straight from register flops, with no extra delay.
- Input path: gpio_in passes through 2 sync flops (s1, s2) into DIN, then 1 further flop (prev).
  - Rising event on a pin: s2 & ~prev. Falling event: ~s2 & prev. IRQ_POL selects which one is used per pin.
  - An input toggle appears in DIN 2 cycles later. Its IRQ_STAT bit sets 3 edges after the toggle.
- IRQ_STAT: a bit sets on its selected event regardless of IRQ_EN. It clears only by a write of 1 in an enabled byte lane.
  - If an event and a W1C on the same bit occur in the same cycle, set wins.
- gpio_irq is registered: gpio_irq <= |(IRQ_STAT & IRQ_EN).
  - Disabling IRQ_EN drops gpio_irq on the next edge; IRQ_STAT is unchanged.
- Reset mid-access: the access is discarded and all state returns to reset values immediately.
- Pins driven as outputs are still sampled on gpio_in and still generate events.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle, after DOUT has been written to 0xFFFF_FFFF -> gpio_out, gpio_oe, gpio_irq and dout go to 0 immediately without a clock edge; ready_nxt=0 until release.
- Byte writes: write 0xA5A5_A5A5 to 0x00 with bytesel=0xF, then 0x1234_5678 with bytesel=0x2 -> gpio_out=0xA5A5_56A5; a read of 0x00 gives dout=0xA5A5_56A5 one cycle later.
- Input sync and read: gpio_in toggles from 0 to 0x0000_0001 -> DIN reads 0 if sampled 1 cycle after the toggle and 0x0000_0001 if sampled 2 cycles after; reserved offset 0x40 reads 0; address 0x100 aliases to 0x00.
- Rising interrupt: IRQ_EN=0x1, IRQ_POL=0, pin0 rises -> IRQ_STAT=0x1 after 3 edges and gpio_irq=1 one edge later; W1C 0x1 to 0x14 -> IRQ_STAT=0 and gpio_irq=0 the following edge.
- Falling and masked events: IRQ_POL=0x2, pin1 falls with IRQ_EN=0 -> IRQ_STAT=0x2 and gpio_irq stays 0; then setting IRQ_EN=0x2 -> gpio_irq=1 on the next edge.
- Set wins over clear: W1C of bit0 in the same cycle as a pin0 rising event -> IRQ_STAT bit0 remains 1.
